// File: rtl/biu_arbiter.sv
// Round-robin arbiter sharing one BIU master port among NUM_MASTERS one-deep request slots; s_en -> m_en in 2 cycles.
// m_en and its fields hold while m_busy=1; a request to a master whose slot is still busy is dropped.
module biu_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_MASTERS = 4,
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_address,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_data_out,
    input  logic [NUM_MASTERS-1:0]            s_rnw,
    input  logic [NUM_MASTERS-1:0]            s_en,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_data_in,
    output logic [NUM_MASTERS-1:0]            s_data_valid,
    output logic [NUM_MASTERS-1:0]            s_busy,
    output logic [ADDR_WIDTH-1:0]             m_address,
    output logic [DATA_WIDTH-1:0]             m_data_out,
    output logic                              m_rnw,
    output logic                              m_en,
    input  logic [DATA_WIDTH-1:0]             m_data_in,
    input  logic                              m_data_valid,
    input  logic                              m_busy,
    output logic [IW-1:0]                     grant_id,
    output logic                              active
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NUM_MASTERS-1:0] pend_vld;
    logic [NUM_MASTERS-1:0] pend_rnw;
    logic [ADDR_WIDTH-1:0]  pend_addr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  pend_data [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  rd_data   [NUM_MASTERS];

    logic [IW-1:0] ptr;
    logic [IW-1:0] pick;
    logic [IW-1:0] ptr_nxt;
    logic [IW:0]   rot;
    logic          pick_vld;
    logic          load;
    logic          accept;
    logic          rd_done;
    logic          retire;

    // First pending slot at or after ptr, wrapping modulo NUM_MASTERS.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        rot      = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            rot = {1'b0, ptr} + (IW+1)'(k);
            if (rot >= (IW+1)'(NUM_MASTERS)) begin
                rot = rot - (IW+1)'(NUM_MASTERS);
            end
            if (!pick_vld && pend_vld[rot[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = rot[IW-1:0];
            end
        end
    end

    assign ptr_nxt = (pick == IW'(NUM_MASTERS - 1)) ? '0 : pick + IW'(1);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        rd_done   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!m_busy) begin
                    accept    = 1'b1;
                    state_nxt = m_rnw ? WAIT_RD : IDLE;
                end
            end
            WAIT_RD: begin
                if (m_data_valid) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Writes are posted: the slot frees as soon as the downstream port takes the request.
    assign retire = (accept && !m_rnw) || rd_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld     <= '0;
            pend_rnw     <= '0;
            ptr          <= '0;
            grant_id     <= '0;
            m_address    <= '0;
            m_data_out   <= '0;
            m_rnw        <= 1'b0;
            m_en         <= 1'b0;
            s_data_valid <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                pend_addr[i] <= '0;
                pend_data[i] <= '0;
                rd_data[i]   <= '0;
            end
        end else begin
            s_data_valid <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (s_en[i] && !pend_vld[i]) begin
                    pend_vld[i]  <= 1'b1;
                    pend_rnw[i]  <= s_rnw[i];
                    pend_addr[i] <= s_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                    pend_data[i] <= s_data_out[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (retire && grant_id == IW'(i)) begin
                    pend_vld[i] <= 1'b0;
                end
                if (rd_done && grant_id == IW'(i)) begin
                    rd_data[i]      <= m_data_in;
                    s_data_valid[i] <= 1'b1;
                end
            end
            if (load) begin
                grant_id   <= pick;
                m_address  <= pend_addr[pick];
                m_data_out <= pend_data[pick];
                m_rnw      <= pend_rnw[pick];
                m_en       <= 1'b1;
                ptr        <= ptr_nxt;
            end
            if (accept) begin
                m_en <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_rd_flat
        assign s_data_in[g*DATA_WIDTH +: DATA_WIDTH] = rd_data[g];
    end

    assign s_busy = pend_vld;
    assign active = (state != IDLE);

endmodule
